// File: rtl/fsm_txrespscheduler_if.sv
// Response-collection and TX-FIFO handshake bundle for the TX response scheduler.
// The master side is the requesters plus the TX FIFO; the slave side is the scheduler.
interface fsm_txrespscheduler_if #(
    parameter int DATA_WIDTH       = 32,
    parameter int CMD_OUTPUT_WIDTH = 5,
    parameter int MODULES_CNT      = 13
);
    logic [MODULES_CNT-1:0]                        i_resp_valid;
    logic [MODULES_CNT-1:0][CMD_OUTPUT_WIDTH-1:0]  i_resp_cmd;
    logic [MODULES_CNT-1:0][DATA_WIDTH-1:0]        i_resp_data;
    logic [MODULES_CNT-1:0]                        o_resp_ready;
    logic [DATA_WIDTH-1:0]                         o_tx_data;
    logic                                          o_tx_valid;
    logic                                          i_tx_ready;

    modport master (
        output i_resp_valid, i_resp_cmd, i_resp_data, i_tx_ready,
        input  o_resp_ready, o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_resp_valid, i_resp_cmd, i_resp_data, i_tx_ready,
        output o_resp_ready, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/fsm_txrespscheduler.sv
// TX response scheduler: round-robin picks one pending requester, captures its
// command echo and read data, then emits a header word and a data word to the TX FIFO.
module fsm_txrespscheduler #(
    parameter int DATA_WIDTH          = 32,
    parameter int CMD_OUTPUT_WIDTH    = 5,
    parameter int MODULE_SELECT_WIDTH = 5,
    parameter int MODULES_CNT         = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_enable,
    fsm_txrespscheduler_if.slave        bus,
    output logic                        o_busy,
    output logic [15:0]                 o_resp_count
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [MODULE_SELECT_WIDTH-1:0] LAST_IDX = MODULE_SELECT_WIDTH'(MODULES_CNT - 1);

    logic [1:0]                        state_r;
    logic [MODULE_SELECT_WIDTH-1:0]    rr_ptr_r;
    logic [MODULE_SELECT_WIDTH-1:0]    winner_r;
    logic [CMD_OUTPUT_WIDTH-1:0]       cmd_r;
    logic [DATA_WIDTH-1:0]             data_r;
    logic [DATA_WIDTH-1:0]             tx_data_r;
    logic                              tx_valid_r;
    logic                              busy_r;
    logic [15:0]                       resp_count_r;

    logic [MODULES_CNT-1:0]            ge_mask_s;
    logic [MODULES_CNT-1:0]            req_s;
    logic [MODULES_CNT-1:0]            pick_s;
    logic [MODULES_CNT-1:0]            resp_ready_s;
    logic                              grant_found_s;
    logic [MODULE_SELECT_WIDTH-1:0]    grant_idx_s;
    logic [CMD_OUTPUT_WIDTH-1:0]       grant_cmd_s;
    logic [DATA_WIDTH-1:0]             grant_data_s;

    // Header layout: bit 0 marks a header, then module index, then command echo, rest zero.
    function automatic logic [DATA_WIDTH-1:0] build_header(
        input logic [MODULE_SELECT_WIDTH-1:0] idx,
        input logic [CMD_OUTPUT_WIDTH-1:0]    cmd
    );
        logic [DATA_WIDTH-1:0] hdr;
        hdr = '0;
        hdr[0] = 1'b1;
        hdr[MODULE_SELECT_WIDTH:1] = idx;
        hdr[MODULE_SELECT_WIDTH+CMD_OUTPUT_WIDTH:MODULE_SELECT_WIDTH+1] = cmd;
        return hdr;
    endfunction

    // Round-robin arbiter: lowest pending index at or above rr_ptr wins, else lowest overall.
    always_comb begin
        grant_idx_s  = '0;
        grant_cmd_s  = '0;
        grant_data_s = '0;
        resp_ready_s = '0;
        for (int j = 0; j < MODULES_CNT; j++) begin
            ge_mask_s[j] = (MODULE_SELECT_WIDTH'(j) >= rr_ptr_r);
        end
        // Grants only in IDLE, only when enabled and never while reset is held.
        req_s  = (rst && (state_r == ST_IDLE) && i_enable) ? bus.i_resp_valid : '0;
        pick_s = (|(req_s & ge_mask_s)) ? (req_s & ge_mask_s) : req_s;
        grant_found_s = |pick_s;
        // Scan downward so the lowest set bit of pick_s is the final survivor.
        for (int j = MODULES_CNT - 1; j >= 0; j--) begin
            grant_idx_s  = pick_s[j] ? MODULE_SELECT_WIDTH'(j) : grant_idx_s;
            grant_cmd_s  = pick_s[j] ? bus.i_resp_cmd[j]       : grant_cmd_s;
            grant_data_s = pick_s[j] ? bus.i_resp_data[j]      : grant_data_s;
        end
        for (int j = 0; j < MODULES_CNT; j++) begin
            resp_ready_s[j] = grant_found_s && (grant_idx_s == MODULE_SELECT_WIDTH'(j));
        end
    end

    // Scheduler FSM: capture on grant, offer header then data, advance pointer on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            winner_r     <= '0;
            cmd_r        <= '0;
            data_r       <= '0;
            tx_data_r    <= '0;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
            resp_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        state_r    <= ST_HDR;
                        winner_r   <= grant_idx_s;
                        cmd_r      <= grant_cmd_s;
                        data_r     <= grant_data_s;
                        tx_data_r  <= build_header(grant_idx_s, grant_cmd_s);
                        tx_valid_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        tx_data_r  <= '0;
                        tx_valid_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_HDR: begin
                    if (bus.i_tx_ready) begin
                        state_r   <= ST_DATA;
                        tx_data_r <= data_r;
                    end else begin
                        // Header rebuilt from the captured fields, so it cannot drift.
                        tx_data_r <= build_header(winner_r, cmd_r);
                    end
                end
                ST_DATA: begin
                    if (bus.i_tx_ready) begin
                        state_r      <= ST_IDLE;
                        tx_data_r    <= '0;
                        tx_valid_r   <= 1'b0;
                        busy_r       <= 1'b0;
                        rr_ptr_r     <= (winner_r == LAST_IDX) ? '0 : winner_r + 1'b1;
                        resp_count_r <= resp_count_r + 16'd1;
                    end else begin
                        tx_data_r <= data_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    tx_data_r  <= '0;
                    tx_valid_r <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_resp_ready = resp_ready_s;
    assign bus.o_tx_data    = tx_data_r;
    assign bus.o_tx_valid   = tx_valid_r;
    assign o_busy           = busy_r;
    assign o_resp_count     = resp_count_r;
endmodule

// File: tb/tb_fsm_txrespscheduler.sv
// Scoreboard bench for fsm_txrespscheduler: a transaction-level model predicts grants
// and TX words into queues; an independent monitor pops and compares what the DUT shows.
module tb_fsm_txrespscheduler;
    localparam int N  = 13;
    localparam int DW = 32;
    localparam int CW = 5;
    localparam int MW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        busy;
    logic [15:0] cnt;

    fsm_txrespscheduler_if #(.DATA_WIDTH(DW), .CMD_OUTPUT_WIDTH(CW), .MODULES_CNT(N)) bus ();

    fsm_txrespscheduler #(
        .DATA_WIDTH(DW), .CMD_OUTPUT_WIDTH(CW), .MODULE_SELECT_WIDTH(MW), .MODULES_CNT(N)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(en), .bus(bus), .o_busy(busy), .o_resp_count(cnt)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [N-1:0]  grant_q[$];
    logic [DW-1:0] tx_q[$];

    // Transaction-level model state
    int          m_rr;
    int          m_words;
    int          m_win;
    bit          m_pend;
    bit          last_txr;
    logic [15:0] m_count;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] hdr_word(input int idx, input logic [CW-1:0] cmd);
        return DW'(1) + DW'(idx) * 2 + (DW'(cmd) << (MW + 1));
    endfunction

    task automatic model_reset();
        grant_q.delete();
        tx_q.delete();
        m_rr = 0; m_words = 0; m_win = 0; m_pend = 1'b0; last_txr = 1'b0; m_count = 16'd0;
    endtask

    // One cycle: account for the edge just passed, drive new inputs, predict any grant.
    task automatic step(input logic [N-1:0] v, input bit e, input bit txr, input bit rnd);
        @(negedge clk);
        if (m_pend) begin
            m_words = 2;
            m_pend  = 1'b0;
        end else if (m_words > 0 && last_txr) begin
            m_words--;
            if (m_words == 0) begin
                m_count++;
                m_rr = (m_win + 1) % N;
            end
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                bus.i_resp_cmd[i]  = CW'($urandom);
                bus.i_resp_data[i] = $urandom;
            end
        end
        bus.i_resp_valid = v;
        en = e;
        bus.i_tx_ready = txr;
        last_txr = txr;
        if (m_words == 0 && e && v != '0) begin
            m_win = rr_pick(v, m_rr);
            grant_q.push_back(N'(1) << m_win);
            tx_q.push_back(hdr_word(m_win, bus.i_resp_cmd[m_win]));
            tx_q.push_back(bus.i_resp_data[m_win]);
            m_pend = 1'b1;
        end
    endtask

    logic [DW-1:0] prev_data;
    bit            prev_stall = 1'b0;

    // Monitor: sample mid-low-phase, pop expectations whenever the DUT presents something.
    always @(negedge clk) begin
        #2;
        if (mon_en && rst) begin
            if (bus.o_resp_ready != '0) begin
                if (grant_q.size() == 0) begin
                    n_total++;
                    $display("FAIL grant: actual=%0h required=none", bus.o_resp_ready);
                end else begin
                    chk("grant", bus.o_resp_ready, grant_q.pop_front());
                end
            end
            chk("tx_valid", bus.o_tx_valid, m_words > 0);
            chk("busy", busy, m_words > 0);
            chk("resp_count", cnt, m_count);
            if (!bus.o_tx_valid) chk("tx_data_idle", bus.o_tx_data, 64'd0);
            if (prev_stall) chk("tx_data_stable", bus.o_tx_data, prev_data);
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (tx_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_word: actual=%0h required=none", bus.o_tx_data);
                end else begin
                    chk("tx_word", bus.o_tx_data, tx_q.pop_front());
                end
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        bus.i_resp_valid = '0;
        bus.i_tx_ready   = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.i_resp_cmd[i]  = '0;
            bus.i_resp_data[i] = '0;
        end
        model_reset();
        en = 1'b1;

        // Reset state, with every requester pending and enable high
        bus.i_resp_valid = '1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", bus.o_resp_ready, 64'd0);
        chk("rst_tx_valid", bus.o_tx_valid, 64'd0);
        chk("rst_tx_data", bus.o_tx_data, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_count", cnt, 64'd0);
        bus.i_resp_valid = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        // Single request from module 3
        bus.i_resp_cmd[3]  = 5'd5;
        bus.i_resp_data[3] = 32'hDEADBEEF;
        step(N'(1) << 3, 1'b1, 1'b1, 1'b0);
        repeat (4) step('0, 1'b1, 1'b1, 1'b0);
        chk("single_count", cnt, 64'd1);

        // Reset while the data word is stalled
        step(N'(1) << 5, 1'b1, 1'b1, 1'b1);
        step(N'(1) << 5, 1'b1, 1'b1, 1'b1);
        step('0, 1'b1, 1'b0, 1'b1);
        bus.i_resp_valid = '1;
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_tx_valid", bus.o_tx_valid, 64'd0);
        chk("mid_rst_tx_data", bus.o_tx_data, 64'd0);
        chk("mid_rst_busy", busy, 64'd0);
        chk("mid_rst_count", cnt, 64'd0);
        chk("mid_rst_ready", bus.o_resp_ready, 64'd0);
        model_reset();
        bus.i_resp_valid = '0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;

        // All requesters pending: 0..12 then 0, one grant per 3 cycles
        repeat (40) step('1, 1'b1, 1'b1, 1'b1);
        chk("all_valid_count", cnt, 64'd13);
        repeat (3) step('0, 1'b1, 1'b1, 1'b1);

        // Backpressure in header and data phases, request held throughout
        step(N'(1) << 7, 1'b1, 1'b1, 1'b1);
        repeat (5) step(N'(1) << 7, 1'b1, 1'b0, 1'b1);
        step(N'(1) << 7, 1'b1, 1'b1, 1'b1);
        repeat (5) step(N'(1) << 7, 1'b1, 1'b0, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1, 1'b1);
        chk("backpressure_count", cnt, 64'd15);

        // Enable low blocks grants; re-enable resumes at the pointer
        repeat (6) step('1, 1'b0, 1'b1, 1'b1);
        chk("disabled_busy", busy, 64'd0);
        repeat (4) step('1, 1'b1, 1'b1, 1'b1);
        repeat (4) step('0, 1'b1, 1'b1, 1'b1);

        // Counter wrap from 0xFFFF
        #3 force dut.resp_count_r = 16'hFFFF;
        #1 release dut.resp_count_r;
        m_count = 16'hFFFF;
        step(N'(1) << 0, 1'b1, 1'b1, 1'b1);
        repeat (3) step('0, 1'b1, 1'b1, 1'b1);
        chk("wrap_count", cnt, 64'd0);

        // Randomized traffic with enable and backpressure
        for (int c = 0; c < 2000; c++) begin
            step(N'($urandom) & N'($urandom), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 7, 1'b1);
        end

        // Drain and confirm every prediction was consumed
        repeat (10) step('0, 1'b1, 1'b1, 1'b1);
        chk("grant_q_empty", grant_q.size(), 64'd0);
        chk("tx_q_empty", tx_q.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
